// File: rtl/ws2812_chain_if.sv
// Host-side bus of the WS2812 chain driver: colour writes, frame requests and line status.
interface ws2812_chain_if #(
    parameter int ADDR_W = 8
) ();
    // wr_en and update are strobes with no back-pressure. Each one is taken on every
    // rising clk edge where it is high, and nothing is ever stalled. busy and data are
    // pure status outputs.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_color;
    logic              update;
    logic              busy;
    logic              data;

    modport master (output wr_en, wr_addr, wr_color, update, input busy, data);
    modport slave  (input wr_en, wr_addr, wr_color, update, output busy, data);
endinterface

// File: rtl/ws2812_chain.sv
// WS2812 chain driver: a colour memory is streamed as GRB words, MSB first, with
// one-wire bit timing, and each frame is followed by a latch gap.
module ws2812_chain #(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = 8,
    parameter int T0H_CYC  = 11,
    parameter int T0L_CYC  = 24,
    parameter int T1H_CYC  = 24,
    parameter int T1L_CYC  = 11,
    parameter int RES_CYC  = 1500
) (
    input  logic           clk,
    input  logic           reset,
    ws2812_chain_if.slave  bus,
    output logic [1:0]     dbg_state
);
    localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int MAX_H   = (T0H_CYC > T1H_CYC) ? T0H_CYC : T1H_CYC;
    localparam int MAX_L   = (T0L_CYC > T1L_CYC) ? T0L_CYC : T1L_CYC;
    localparam int MAX_B   = (MAX_H > MAX_L) ? MAX_H : MAX_L;
    localparam int MAX_CYC = (MAX_B > RES_CYC) ? MAX_B : RES_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HIGH = 2'd1,
        SEND_LOW  = 2'd2,
        LATCH     = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, ph_last;
    logic [4:0]        bit_idx, bit_next;
    logic [LED_W-1:0]  led_idx, led_next, led_inc, wr_idx;
    logic [23:0]       word, word_next;
    logic [ADDR_W-1:0] wr_addr;
    logic              dirty, dirty_clr, wr_ok, phase_done, data_q;

    // Power-up contents are zero; reset deliberately leaves the colours alone.
    logic [23:0] mem [NUM_LEDS] = '{default: 24'h000000};

    assign wr_addr = bus.wr_addr;
    assign wr_ok   = bus.wr_en && (int'(wr_addr) < NUM_LEDS);
    assign wr_idx  = LED_W'(wr_addr);
    assign led_inc = led_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= bus.wr_color;
        end
    end

    // A set in the same cycle as the IDLE clear wins, so that request is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            dirty <= 1'b0;
        end else begin
            dirty <= wr_ok || bus.update || (dirty && !dirty_clr);
        end
    end

    always_comb begin
        ph_last = '0;
        case (state)
            SEND_HIGH: ph_last = word[23] ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
            SEND_LOW:  ph_last = word[23] ? CNT_W'(T1L_CYC - 1) : CNT_W'(T0L_CYC - 1);
            LATCH:     ph_last = CNT_W'(RES_CYC - 1);
            default:   ph_last = '0;
        endcase
    end

    assign phase_done = (cnt == ph_last);

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        bit_next   = bit_idx;
        led_next   = led_idx;
        word_next  = word;
        dirty_clr  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (dirty) begin
                    state_next = SEND_HIGH;
                    dirty_clr  = 1'b1;
                    word_next  = mem[0];
                    bit_next   = '0;
                    led_next   = '0;
                end
            end
            SEND_HIGH: begin
                if (phase_done) begin
                    state_next = SEND_LOW;
                    cnt_next   = '0;
                end
            end
            SEND_LOW: begin
                if (phase_done) begin
                    cnt_next = '0;
                    if (bit_idx != 5'd23) begin
                        state_next = SEND_HIGH;
                        bit_next   = bit_idx + 1'b1;
                        word_next  = {word[22:0], 1'b0};
                    end else if (led_idx == LED_W'(NUM_LEDS - 1)) begin
                        state_next = LATCH;
                    end else begin
                        // The next word is sampled on the last cycle of the current word,
                        // which keeps the bit stream gap-free across LED boundaries.
                        state_next = SEND_HIGH;
                        bit_next   = '0;
                        led_next   = led_inc;
                        word_next  = mem[led_inc];
                    end
                end
            end
            LATCH: begin
                if (phase_done) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = LATCH;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LATCH;
            cnt     <= '0;
            bit_idx <= '0;
            led_idx <= '0;
            word    <= '0;
            data_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            led_idx <= led_next;
            word    <= word_next;
            data_q  <= (state_next == SEND_HIGH);
        end
    end

    assign bus.data  = data_q;
    assign bus.busy  = (state != IDLE) && !reset;
    assign dbg_state = state;
endmodule

// File: doc/ws2812_chain.md
WS2812_CHAIN -- requirements
Module: ws2812_chain

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning LEDs in chain (1..256).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning width of wr_addr.
REQ-003 SHALL have parameters T0H_CYC / T0L_CYC / T1H_CYC / T1L_CYC, defaults 11 / 24 / 24 / 11, meaning clk cycles of high/low phase for a 0-bit / 1-bit.
REQ-004 SHALL have parameter RES_CYC, default 1500, meaning clk cycles of low latch gap after a frame.
REQ-005 SHALL have port clk, input, 1, meaning single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, meaning write strobe for one colour word.
REQ-008 SHALL have port wr_addr, input, ADDR_W, meaning LED index to write.
REQ-009 SHALL have port wr_color, input, 24, meaning colour word, wire order GRB, bit 23 sent first.
REQ-010 SHALL have port update, input, 1, meaning request a frame even if no colour changed.
REQ-011 SHALL have port busy, output, 1, meaning frame or latch gap in progress.
REQ-012 SHALL have port data, output, 1, meaning registered serial line to the first LED.

Function
REQ-013 SHALL hold a NUM_LEDS x 24 colour memory, initialised to 0 at configuration and not cleared by reset.
REQ-014 SHALL write wr_color to memory[wr_addr] on any cycle with wr_en=1 and wr_addr<NUM_LEDS, including during a frame.
REQ-015 SHALL ignore writes with wr_addr>=NUM_LEDS: no memory change, no dirty flag.
REQ-016 SHALL set a dirty flag on every accepted write and on every cycle with update=1.
REQ-017 SHALL use states IDLE, SEND_HIGH, SEND_LOW, LATCH.
REQ-018 IDLE: data=0, busy=0; with dirty=1, SHALL clear dirty, load LED 0 word, and enter SEND_HIGH next cycle.
REQ-019 A write or update in the same cycle that dirty is cleared SHALL leave dirty=1 (set wins).
REQ-020 SHALL send LEDs in index order 0..NUM_LEDS-1, each word MSB first, 24 bits per LED.
REQ-021 SEND_HIGH SHALL drive data=1 for exactly T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles, then enter SEND_LOW.
REQ-022 SEND_LOW SHALL drive data=0 for exactly T1L_CYC or T0L_CYC cycles, then the next bit's SEND_HIGH.
REQ-023 Bit periods SHALL be contiguous: no extra cycles between bits or between LEDs; the next word is fetched before the current word's last bit ends.
REQ-024 Each LED word SHALL be sampled from memory at its fetch; writes after the fetch appear in the next frame.
REQ-025 After the low phase of bit 0 of LED NUM_LEDS-1, SHALL enter LATCH: data=0 for exactly RES_CYC cycles, then IDLE.
REQ-026 busy SHALL be 1 in SEND_HIGH, SEND_LOW and LATCH, 0 in IDLE.
REQ-027 A dirty flag set during a frame SHALL start the next frame on the first IDLE cycle after LATCH.
REQ-028 Bit and LED counters SHALL be sized for NUM_LEDS and 24 and SHALL NOT wrap within a frame.

Reset
REQ-029 While reset=1: data=0, busy=0, dirty=0, counters 0; state forced to LATCH with counter 0.
REQ-030 After release, SHALL run a full RES_CYC latch gap (busy=1, data=0) before IDLE, even when asserted mid-bit.

Verification (NUM_LEDS=2, T0H=2, T0L=4, T1H=4, T1L=2, RES_CYC=8)
REQ-031 Reset 3 cycles, release -> data=0, busy=1 for 8 cycles, then busy=0; no frame without writes.
REQ-032 Write LED0=0x800001 in IDLE -> frame of 48 bits: first bit 4 high/2 low, bit 0 of LED0 4/2, all others 2/4, then 8 low cycles; busy=1 throughout.
REQ-033 Write LED1=0xFFFFFF during LED0 transmission -> same frame carries it; dirty re-set, second frame follows immediately after LATCH.
REQ-034 update=1 only, no writes -> frame re-sends stored colours unchanged.
REQ-035 wr_addr=5 write -> no frame, memory unchanged; reset mid-frame -> data=0 next cycle, 8-cycle latch after release.
